// File: rtl/nios_avalon_st_adapter_timing_fifo_if.sv
// Avalon-ST beat bundle used on both sides of the timing FIFO.
//   master : drives valid/data/error/startofpacket/endofpacket/empty, samples ready
//   slave  : samples the beat fields, drives ready
// Ready latency is 0. A beat transfers on a rising edge where valid & ready.
interface nios_avalon_st_adapter_timing_fifo_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned EMPTY_W = 2,
  parameter int unsigned ERR_W   = 1
) ();
  logic               ready;
  logic               valid;
  logic [DATA_W-1:0]  data;
  logic [ERR_W-1:0]   error;
  logic               startofpacket;
  logic               endofpacket;
  logic [EMPTY_W-1:0] empty;

  modport master (
    output valid, data, error, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  valid, data, error, startofpacket, endofpacket, empty,
    output ready
  );
endinterface

// File: rtl/nios_avalon_st_adapter_timing_fifo.sv
// Avalon-ST timing FIFO placed downstream of the Nios adapter's error adapter. It buffers
// accepted beats in a small synchronous FIFO so that upstream ready never depends
// combinationally on downstream ready.
// Ports:
//   clk        : single clock, rising edge
//   reset_n    : synchronous active-low reset
//   in_if      : Avalon-ST sink (slave modport), ready driven from registers only
//   out_if     : Avalon-ST source (master modport), fields zero while not valid
//   fill_level : occupied entries, 0..DEPTH
//   pkt_err    : sticky framing error flag
// Optional feature: define TA_PKT_CHECK_EN to enable the sop/eop framing checker.
// Without it pkt_err is tied to 0.
module nios_avalon_st_adapter_timing_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned EMPTY_W = 2,
  parameter int unsigned ERR_W   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  nios_avalon_st_adapter_timing_fifo_if.slave  in_if,
  nios_avalon_st_adapter_timing_fifo_if.master out_if,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     pkt_err
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = ERR_W + 3 + EMPTY_W + DATA_W;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [EntryW-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop;
  logic              out_valid;

  logic [ERR_W-1:0]   head_error;
  logic               head_sop, head_eop;
  logic [EMPTY_W-1:0] head_empty;
  logic [DATA_W-1:0]  head_data;

  // Ready comes only from the count register; no pass-through when full.
  assign in_if.ready = reset_n && (count_q != Full);
  assign out_valid   = reset_n && (count_q != '0);
  assign push        = in_if.valid && in_if.ready;
  assign pop         = out_valid && out_if.ready;
  assign fill_level  = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is intentionally not reset; push is already gated by reset_n.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_if.error, in_if.startofpacket, in_if.endofpacket,
                        in_if.empty, in_if.data};
    end
  end

  assign {head_error, head_sop, head_eop, head_empty, head_data} = mem[rd_ptr_q];

  always_comb begin
    out_if.valid         = out_valid;
    out_if.data          = '0;
    out_if.error         = '0;
    out_if.startofpacket = 1'b0;
    out_if.endofpacket   = 1'b0;
    out_if.empty         = '0;
    if (out_valid) begin
      out_if.data          = head_data;
      out_if.error         = head_error;
      out_if.startofpacket = head_sop;
      out_if.endofpacket   = head_eop;
      out_if.empty         = head_empty;
    end
  end

`ifdef TA_PKT_CHECK_EN
  typedef enum logic {StIdle, StInPkt} pkt_state_e;

  pkt_state_e state_q, state_d;
  logic       err_q, err_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // After any pushed beat, eop means the packet is closed and anything else means we are
  // inside one; this also gives the recovery state after a violation.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (push) begin
      if ((state_q == StIdle && !in_if.startofpacket) ||
          (state_q == StInPkt && in_if.startofpacket)) begin
        err_d = 1'b1;
      end
      state_d = in_if.endofpacket ? StIdle : StInPkt;
    end
  end

  assign pkt_err = err_q;
`else
  assign pkt_err = 1'b0;
`endif

endmodule

// File: tb/tb_nios_avalon_st_adapter_timing_fifo.sv
module tb_nios_avalon_st_adapter_timing_fifo;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned EMPTY_W = 2;
  localparam int unsigned ERR_W   = 1;

  typedef struct packed {
    logic [ERR_W-1:0]   err;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } beat_t;

  logic       clk;
  logic       reset_n;
  logic [2:0] fill_level;
  logic       pkt_err;

  nios_avalon_st_adapter_timing_fifo_if #(
    .DATA_W (DATA_W),
    .EMPTY_W(EMPTY_W),
    .ERR_W  (ERR_W)
  ) in_if ();
  nios_avalon_st_adapter_timing_fifo_if #(
    .DATA_W (DATA_W),
    .EMPTY_W(EMPTY_W),
    .ERR_W  (ERR_W)
  ) out_if ();

  nios_avalon_st_adapter_timing_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .EMPTY_W(EMPTY_W),
    .ERR_W  (ERR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_if     (in_if),
    .out_if    (out_if),
    .fill_level(fill_level),
    .pkt_err   (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of accepted beats plus a packet-open flag.
  beat_t q[$];
  logic  m_in_pkt = 1'b0;
  logic  m_err    = 1'b0;
  logic  chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs present at the edge, then return
  // shortly after the following falling edge so new inputs never race the compare process.
  task automatic tick();
    beat_t b;
    logic  do_push, do_pop;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      m_in_pkt = 1'b0;
      m_err    = 1'b0;
    end else begin
      do_push = in_if.valid && (q.size() < DEPTH);
      do_pop  = out_if.ready && (q.size() != 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        b = '{err: in_if.error, sop: in_if.startofpacket, eop: in_if.endofpacket,
              empty: in_if.empty, data: in_if.data};
        q.push_back(b);
        if ((!m_in_pkt && !b.sop) || (m_in_pkt && b.sop)) m_err = 1'b1;
        m_in_pkt = !b.eop;
      end
    end
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    beat_t exp_b;
    logic  exp_valid;
    if (chk_en) begin
      exp_valid = reset_n && (q.size() != 0);
      exp_b     = exp_valid ? q[0] : '0;
      chk("in_ready", 64'(in_if.ready), 64'(reset_n && (q.size() < DEPTH)));
      chk("out_valid", 64'(out_if.valid), 64'(exp_valid));
      chk("fill_level", 64'(fill_level), 64'(q.size()));
      chk("out_data", 64'(out_if.data), 64'(exp_b.data));
      chk("out_error", 64'(out_if.error), 64'(exp_b.err));
      chk("out_sop", 64'(out_if.startofpacket), 64'(exp_b.sop));
      chk("out_eop", 64'(out_if.endofpacket), 64'(exp_b.eop));
      chk("out_empty", 64'(out_if.empty), 64'(exp_b.empty));
`ifdef TA_PKT_CHECK_EN
      chk("pkt_err", 64'(pkt_err), 64'(m_err));
`else
      chk("pkt_err", 64'(pkt_err), 64'd0);
`endif
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic e, input logic s,
                       input logic eo, input logic [1:0] em);
    in_if.valid         = v;
    in_if.data          = d;
    in_if.error         = e;
    in_if.startofpacket = s;
    in_if.endofpacket   = eo;
    in_if.empty         = em;
  endtask

  initial begin
    reset_n      = 1'b0;
    out_if.ready = 1'b0;
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 2'd0);

    // Reset holds everything off even with in_valid high.
    tick();
    tick();
    chk("rst_in_ready", 64'(in_if.ready), 64'd0);
    chk("rst_out_valid", 64'(out_if.valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_out_data", 64'(out_if.data), 64'd0);

    // Single beat, one-cycle latency.
    reset_n      = 1'b1;
    out_if.ready = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 2'd2);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("one_valid", 64'(out_if.valid), 64'd1);
    chk("one_data", 64'(out_if.data), 64'hDEAD_BEEF);
    chk("one_err", 64'(out_if.error), 64'd1);
    chk("one_empty", 64'(out_if.empty), 64'd2);
    chk("one_sopeop", 64'({out_if.startofpacket, out_if.endofpacket}), 64'd3);
    tick();
    chk("one_fill_after", 64'(fill_level), 64'd0);

    // Fill to DEPTH with a fifth beat held off, then drain in order.
    out_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b1, 1'b1, 2'd0);
      tick();
    end
    chk("full_fill", 64'(fill_level), 64'd4);
    chk("full_in_ready", 64'(in_if.ready), 64'd0);
    chk("full_head", 64'(out_if.data), 64'd0);
    out_if.ready = 1'b1;
    tick();
    chk("drain_head1", 64'(out_if.data), 64'd1);
    chk("drain_fill1", 64'(fill_level), 64'd3);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 2; i < 5; i++) begin
      chk("drain_head", 64'(out_if.data), 64'(i));
      tick();
    end
    chk("drain_empty", 64'(out_if.valid), 64'd0);

    // Steady push+pop at level 2 across pointer wrap.
    out_if.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'(100 + i), 1'b0, 1'b1, 1'b1, 2'(i));
      tick();
    end
    out_if.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(102 + i), 1'b0, 1'b1, 1'b1, 2'(i));
      tick();
      chk("stream_fill", 64'(fill_level), 64'd2);
      chk("stream_head", 64'(out_if.data), 64'(101 + i));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    tick();

    // Reset with three beats stored; none may come back.
    out_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(200 + i), 1'b1, 1'b1, 1'b1, 2'd1);
      tick();
    end
    chk("pre_rst_fill", 64'(fill_level), 64'd3);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_fill", 64'(fill_level), 64'd0);
    chk("mid_rst_valid", 64'(out_if.valid), 64'd0);
    reset_n      = 1'b1;
    out_if.ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk("post_rst_valid", 64'(out_if.valid), 64'd0);
    tick();
    chk("post_rst_fill", 64'(fill_level), 64'd0);

    // Framing: sop, then another sop without an eop in between.
    drive(1'b1, 32'd300, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    chk("frame_first", 64'(pkt_err), 64'd0);
    drive(1'b1, 32'd301, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
`ifdef TA_PKT_CHECK_EN
    chk("frame_second", 64'(pkt_err), 64'd1);
`else
    chk("frame_second", 64'(pkt_err), 64'd0);
`endif
    drive(1'b1, 32'd302, 1'b0, 1'b0, 1'b1, 2'd3);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) tick();
`ifdef TA_PKT_CHECK_EN
    chk("frame_sticky", 64'(pkt_err), 64'd1);
`else
    chk("frame_sticky", 64'(pkt_err), 64'd0);
`endif
    chk("final_fill", 64'(fill_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
